// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between two requesters, one op in flight.
// Define ALU_ARB_STATS_EN to add the per-requester saturating grant counters.
module alu_arbiter #(
    parameter int W      = 8,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [W-1:0]      req0_a,
    input  logic [W-1:0]      req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [W-1:0]      rsp0_result,
    output logic              rsp0_z,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [W-1:0]      req1_a,
    input  logic [W-1:0]      req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [W-1:0]      rsp1_result,
    output logic              rsp1_z,
    output logic [W-1:0]      alu_src_a,
    output logic [W-1:0]      alu_src_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [W-1:0]      alu_result,
    input  logic              alu_z,
`ifdef ALU_ARB_STATS_EN
    output logic [7:0]        grant_cnt0,
    output logic [7:0]        grant_cnt1,
`endif
    output logic              busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state;
    logic [W-1:0]      op_a, op_b, res;
    logic [CTRL_W-1:0] op_ctrl;
    logic              zr, owner, last_gnt;
    logic [1:0]        req_valid, gnt, accept;
    logic              rsp_hs;

    assign req_valid = {req1_valid, req0_valid};

    // On a tie the requester that did not win last time takes the ALU.
    always_comb begin
        gnt = 2'b00;
        if (state == IDLE) begin
            if (req_valid == 2'b11)
                gnt = last_gnt ? 2'b01 : 2'b10;
            else
                gnt = req_valid;
        end
    end

    assign accept     = gnt & {2{rst_n}};
    assign req0_ready = accept[0];
    assign req1_ready = accept[1];

    assign rsp0_valid  = (state == RESP) && !owner;
    assign rsp1_valid  = (state == RESP) && owner;
    assign rsp0_result = res;
    assign rsp1_result = res;
    assign rsp0_z      = zr;
    assign rsp1_z      = zr;
    assign rsp_hs      = owner ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);

    assign alu_src_a = op_a;
    assign alu_src_b = op_b;
    assign alu_ctrl  = op_ctrl;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            op_ctrl  <= '0;
            res      <= '0;
            zr       <= 1'b0;
            owner    <= 1'b0;
            last_gnt <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (|accept) begin
                        op_a     <= accept[1] ? req1_a    : req0_a;
                        op_b     <= accept[1] ? req1_b    : req0_b;
                        op_ctrl  <= accept[1] ? req1_ctrl : req0_ctrl;
                        owner    <= accept[1];
                        last_gnt <= accept[1];
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    res   <= alu_result;
                    zr    <= alu_z;
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_hs)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [1:0][7:0] grant_cnt;

    for (genvar i = 0; i < 2; i++) begin : g_stats
        always_ff @(posedge clk) begin
            if (!rst_n)
                grant_cnt[i] <= '0;
            else if (accept[i] && grant_cnt[i] != 8'hFF)
                grant_cnt[i] <= grant_cnt[i] + 8'd1;
        end
    end

    assign grant_cnt0 = grant_cnt[0];
    assign grant_cnt1 = grant_cnt[1];
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed cases plus randomized traffic against a transaction-level model.
module tb_alu_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_z;
    logic       req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_z;
    logic [7:0] req0_a, req0_b, req1_a, req1_b, rsp0_result, rsp1_result;
    logic [2:0] req0_ctrl, req1_ctrl, alu_ctrl;
    logic [7:0] alu_src_a, alu_src_b, alu_result;
    logic       alu_z, busy;
`ifdef ALU_ARB_STATS_EN
    logic [7:0] grant_cnt0, grant_cnt1;
`endif

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.W(8), .CTRL_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ctrl(req0_ctrl), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_z(rsp0_z),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ctrl(req1_ctrl), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_z(rsp1_z),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_z(alu_z),
`ifdef ALU_ARB_STATS_EN
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
        .busy(busy)
    );

    // External ALU: returns {zero, result}; unused ops give 0 with zero set.
    function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [2:0] c);
        logic [7:0] r;
        case (c)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            default: r = 8'h00;
        endcase
        return {r == 8'h00, r};
    endfunction

    always_comb {alu_z, alu_result} = alu_ref(alu_src_a, alu_src_b, alu_ctrl);

    // Transaction model: an op accepted in cycle t is offered from cycle t+2 until consumed.
    bit         m_inflight = 0, m_owner = 0, m_last = 1;
    logic [7:0] m_res = 0;
    bit         m_z = 0;
    int         m_acc_cyc = 0, cyc = 0;
    bit [1:0]   last_acc;
    int         gnt_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v0, input logic [7:0] a0, input logic [7:0] b0, input logic [2:0] c0,
                        input bit v1, input logic [7:0] a1, input logic [7:0] b1, input logic [2:0] c1,
                        input bit rr0, input bit rr1, input bit rst);
        bit e_rdy0, e_rdy1, e_v;
        logic [8:0] r;
        @(negedge clk);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_ctrl = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_ctrl = c1;
        rsp0_ready = rr0; rsp1_ready = rr1; rst_n = !rst;
        #1;
        e_rdy0 = 0; e_rdy1 = 0;
        if (!rst && !m_inflight) begin
            if (v0 && v1) begin
                if (m_last) e_rdy0 = 1; else e_rdy1 = 1;
            end else begin
                e_rdy0 = v0; e_rdy1 = v1;
            end
        end
        e_v = m_inflight && (cyc >= m_acc_cyc + 2);
        chk("req0_ready", req0_ready, e_rdy0);
        chk("req1_ready", req1_ready, e_rdy1);
        chk("rsp0_valid", rsp0_valid, e_v && !m_owner);
        chk("rsp1_valid", rsp1_valid, e_v && m_owner);
        chk("busy", busy, m_inflight);
        if (e_v && !m_owner) begin
            chk("rsp0_result", rsp0_result, m_res);
            chk("rsp0_z", rsp0_z, m_z);
        end
        if (e_v && m_owner) begin
            chk("rsp1_result", rsp1_result, m_res);
            chk("rsp1_z", rsp1_z, m_z);
        end
        last_acc = {e_rdy1, e_rdy0};
        if (rst) begin
            m_inflight = 0; m_last = 1;
        end else if (e_v && (m_owner ? rr1 : rr0)) begin
            m_inflight = 0;
        end else if (e_rdy0 || e_rdy1) begin
            r = e_rdy1 ? alu_ref(a1, b1, c1) : alu_ref(a0, b0, c0);
            m_inflight = 1; m_owner = e_rdy1; m_last = e_rdy1; m_acc_cyc = cyc;
            m_res = r[7:0]; m_z = r[8];
            gnt_log.push_back(int'(e_rdy1));
        end
        cyc++;
    endtask

    task automatic idle(input bit rr0, input bit rr1);
        step(0, 0, 0, 0, 0, 0, 0, 0, rr0, rr1, 0);
    endtask

    task automatic do_reset();
        step(1, 8'h11, 8'h22, 3'd0, 1, 8'h33, 8'h44, 3'd1, 1, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    endtask

    initial begin
        bit         pv[2];
        logic [7:0] pa[2], pb[2];
        logic [2:0] pc[2];
        logic [7:0] held;
        bit         rst_now;

        do_reset();
        idle(1, 1);
        chk("rst_alu_ctrl", alu_ctrl, 3'd0);
        chk("rst_alu_a", alu_src_a, 8'h00);
        chk("rst_busy", busy, 1'b0);

        // 05 + 03 accepted in cycle 0, response in cycle 2
        step(1, 8'h05, 8'h03, 3'd0, 0, 0, 0, 0, 1, 1, 0);
        chk("t1_accept", req0_ready, 1'b1);
        idle(1, 1);
        chk("t1_cyc1_valid", rsp0_valid, 1'b0);
        idle(1, 1);
        chk("t1_valid", rsp0_valid, 1'b1);
        chk("t1_result", rsp0_result, 8'h08);
        chk("t1_z", rsp0_z, 1'b0);

        // 2A - 2A on requester 1
        step(0, 0, 0, 0, 1, 8'h2A, 8'h2A, 3'd1, 1, 1, 0);
        idle(1, 1);
        idle(1, 1);
        chk("t2_valid", rsp1_valid, 1'b1);
        chk("t2_rsp0_quiet", rsp0_valid, 1'b0);
        chk("t2_result", rsp1_result, 8'h00);
        chk("t2_z", rsp1_z, 1'b1);

        // FF + 01 wraps to zero
        step(1, 8'hFF, 8'h01, 3'd0, 0, 0, 0, 0, 1, 1, 0);
        idle(1, 1);
        idle(1, 1);
        chk("t3_result", rsp0_result, 8'h00);
        chk("t3_z", rsp0_z, 1'b1);

        // both valid continuously: grants alternate starting with requester 0
        do_reset();
        gnt_log.delete();
        for (int i = 0; i < 12; i++)
            step(1, 8'h07, 8'h02, 3'd1, 1, 8'h0C, 8'h0A, 3'd4, 1, 1, 0);
        chk("tie_count", gnt_log.size(), 4);
        for (int i = 0; i < gnt_log.size(); i++)
            chk("tie_order", gnt_log[i], i % 2);
        idle(1, 1);

        // response backpressure holds result and blocks the other requester
        step(1, 8'h10, 8'h20, 3'd3, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0);
        step(0, 0, 0, 0, 1, 8'h09, 8'h04, 3'd1, 0, 1, 0);
        held = rsp0_result;
        chk("bp_first", held, 8'h30);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1, 8'h09, 8'h04, 3'd1, 0, 1, 0);
            chk("bp_stable", rsp0_result, held);
            chk("bp_req1_blocked", req1_ready, 1'b0);
        end
        step(0, 0, 0, 0, 1, 8'h09, 8'h04, 3'd1, 1, 1, 0);
        step(0, 0, 0, 0, 1, 8'h09, 8'h04, 3'd1, 1, 1, 0);
        chk("bp_req1_accept", req1_ready, 1'b1);
        idle(1, 1);
        idle(1, 1);
        chk("bp_req1_result", rsp1_result, 8'h05);
        idle(1, 1);

        // reset while the op is in EXEC drops it
        step(1, 8'h03, 8'h04, 3'd2, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        idle(1, 1);
        chk("rx_busy", busy, 1'b0);
        chk("rx_alu_ctrl", alu_ctrl, 3'd0);
        chk("rx_no_rsp", rsp0_valid, 1'b0);
        idle(1, 1);
        idle(1, 1);

        // randomized traffic with backpressure and occasional reset
        pv[0] = 0; pv[1] = 0;
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pv[i] && $urandom_range(0, 2) == 0) begin
                    pv[i] = 1;
                    pa[i] = 8'($urandom);
                    pb[i] = 8'($urandom);
                    pc[i] = 3'($urandom);
                end
            end
            rst_now = ($urandom_range(0, 59) == 0);
            step(pv[0], pa[0], pb[0], pc[0], pv[1], pa[1], pb[1], pc[1],
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rst_now);
            if (last_acc[0]) pv[0] = 0;
            if (last_acc[1]) pv[1] = 0;
        end

`ifdef ALU_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(1, 8'h01, 8'h01, 3'd0, 0, 0, 0, 0, 1, 1, 0);
            idle(1, 1);
            idle(1, 1);
        end
        chk("stats_cnt0", grant_cnt0, 8'd255);
        chk("stats_cnt1", grant_cnt1, 8'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
